// File: rtl/kl8e_pkg.sv
// kl8e console UART controller: shared state encodings, debug struct and
// timeout-counter helpers. Used by kl8e_req_timer and kl8e_uart_ctl.
package kl8e_pkg;

  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_REQ   = 2'd1,
    T_GUARD = 2'd2,
    T_BUSY  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_CAP  = 2'd2
  } rx_state_e;

  // Both FSM states, exported by the top level for observation.
  typedef struct packed {
    tx_state_e tx;
    rx_state_e rx;
  } dbg_state_t;

  // Saturating increment for the timeout counters.
  function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
    return (v == {TIMEOUT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/kl8e_req_timer.sv
// kl8e_req_timer: saturating request-timeout counter. Counts while run_i is
// high and is held at zero otherwise, so every entry into a request state
// starts from zero. expired_o rises in the LIMIT-th cycle of a request, which
// makes the request last exactly LIMIT cycles when no ack arrives.
// LIMIT = 0 disables the timeout.
module kl8e_req_timer
  import kl8e_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(LIMIT - 1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Next count: advance while the request is pending, zero otherwise.
  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = sat_inc(cnt_q);
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = run_i && (LIMIT != 0) && (cnt_q >= LAST);

endmodule

// File: rtl/kl8e_uart_ctl.sv
// kl8e_uart_ctl: processor-side controller for the console UART req/ack
// interface. TX FSM moves TTO bytes to the UART, RX FSM moves UART bytes into
// the TTI buffer. Optional interrupt-enable register under `KL8E_IRQ_EN.
//
// Handshake: this block is the initiator. A request (tx_req / rx_req) is a
// level held high while the FSM sits in its REQ state; the UART answers with
// a one-cycle ack pulse, which ends the request on the next clock edge. If no
// ack arrives within ACK_TIMEOUT cycles the request is dropped and ack_err is
// set. rx_data is sampled in the cycle after rx_ack.
module kl8e_uart_ctl
  import kl8e_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TX_GUARD    = 1
) (
  input  logic       clk,
  input  logic       reset,
`ifdef KL8E_IRQ_EN
  input  logic       ie_set,
  input  logic       ie_clr,
`endif
  input  logic       tto_load,
  input  logic [7:0] tto_data,
  input  logic       tto_flag_clr,
  output logic       tto_flag,
  input  logic       tti_flag_clr,
  output logic       tti_flag,
  output logic [7:0] tti_data,
  output logic       ack_err,
  output logic       irq,
  output logic       tx_req,
  output logic [7:0] tx_data,
  input  logic       tx_ack,
  input  logic       tx_empty,
  output logic       rx_req,
  input  logic       rx_ack,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output dbg_state_t dbg_state
);

  // Last cycle index of the guard window (only used when TX_GUARD > 0).
  localparam logic [7:0] GUARD_LAST = 8'(TX_GUARD - 1);

  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tto_flag_q, tto_flag_d;
  logic [7:0] guard_q, guard_d;

  rx_state_e  rx_state_q, rx_state_d;
  logic [7:0] tti_data_q, tti_data_d;
  logic       tti_flag_q, tti_flag_d;

  logic       ack_err_q, ack_err_d;
  logic       tx_timeout, rx_timeout;
  logic       tx_err, rx_err;

  kl8e_req_timer #(.LIMIT(ACK_TIMEOUT)) u_tx_timer (
    .clk       (clk),
    .reset     (reset),
    .run_i     (tx_state_q == T_REQ),
    .expired_o (tx_timeout)
  );

  kl8e_req_timer #(.LIMIT(ACK_TIMEOUT)) u_rx_timer (
    .clk       (clk),
    .reset     (reset),
    .run_i     (rx_state_q == R_REQ),
    .expired_o (rx_timeout)
  );

  // TX next state: load, request, guard against the stale tx_empty, drain.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tto_flag_d = tto_flag_q;
    guard_d    = guard_q;
    tx_err     = 1'b0;
    // Clear first so that any set below wins over a same-cycle clear.
    if (tto_flag_clr) tto_flag_d = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (tto_load) begin
          tx_data_d  = tto_data;
          tto_flag_d = 1'b0;
          tx_state_d = T_REQ;
        end
      end
      T_REQ: begin
        if (tx_ack) begin
          guard_d    = '0;
          tx_state_d = (TX_GUARD == 0) ? T_BUSY : T_GUARD;
        end else if (tx_timeout) begin
          tx_err     = 1'b1;
          tto_flag_d = 1'b1;
          tx_state_d = T_IDLE;
        end
      end
      T_GUARD: begin
        if (guard_q == GUARD_LAST) tx_state_d = T_BUSY;
        else                       guard_d    = guard_q + 8'd1;
      end
      T_BUSY: begin
        if (tx_empty) begin
          tto_flag_d = 1'b1;
          tx_state_d = T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= T_IDLE;
      tx_data_q  <= '0;
      tto_flag_q <= 1'b0;
      guard_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      tto_flag_q <= tto_flag_d;
      guard_q    <= guard_d;
    end
  end

  // RX next state: request only while the TTI buffer is free, then capture.
  always_comb begin
    rx_state_d = rx_state_q;
    tti_data_d = tti_data_q;
    tti_flag_d = tti_flag_q;
    rx_err     = 1'b0;
    // Clear first so that a capture in the same cycle wins.
    if (tti_flag_clr) tti_flag_d = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rx_empty && !tti_flag_q) rx_state_d = R_REQ;
      end
      R_REQ: begin
        if (rx_ack) begin
          rx_state_d = R_CAP;
        end else if (rx_timeout) begin
          rx_err     = 1'b1;
          rx_state_d = R_IDLE;
        end
      end
      R_CAP: begin
        tti_data_d = rx_data;
        tti_flag_d = 1'b1;
        rx_state_d = R_IDLE;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // RX registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= R_IDLE;
      tti_data_q <= '0;
      tti_flag_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tti_data_q <= tti_data_d;
      tti_flag_q <= tti_flag_d;
    end
  end

  assign ack_err_d = ack_err_q | tx_err | rx_err;

  // Sticky timeout error, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ack_err_q <= 1'b0;
    else       ack_err_q <= ack_err_d;
  end

`ifdef KL8E_IRQ_EN
  logic ie_q, ie_d;

  // Interrupt enable: clear has priority over set.
  always_comb begin
    ie_d = ie_q;
    if (ie_clr)      ie_d = 1'b0;
    else if (ie_set) ie_d = 1'b1;
  end

  // Interrupt-enable register, enabled out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ie_q <= 1'b1;
    else       ie_q <= ie_d;
  end

  assign irq = ie_q & (tto_flag_q | tti_flag_q);
`else
  assign irq = tto_flag_q | tti_flag_q;
`endif

  assign tx_req       = (tx_state_q == T_REQ);
  assign rx_req       = (rx_state_q == R_REQ);
  assign tx_data      = tx_data_q;
  assign tto_flag     = tto_flag_q;
  assign tti_data     = tti_data_q;
  assign tti_flag     = tti_flag_q;
  assign ack_err      = ack_err_q;
  assign dbg_state.tx = tx_state_q;
  assign dbg_state.rx = rx_state_q;

endmodule

// File: doc/kl8e_uart_ctl.md
Name: kl8e_uart_ctl

Overview:
- Processor-side controller for the console UART request/acknowledge interface; this block is the initiator of the handshake.
- Transmit: accepts a byte from the CPU teleprinter (TTO) path, raises tx_req, waits for tx_ack, waits for the transmitter to drain, then sets the TTO done flag.
- Receive: polls rx_empty, issues rx_req, captures rx_data into the keyboard (TTI) buffer and sets the TTI flag.
- Sits between the PDP-8 IOT decode and the UART model / real UART.

Parameters:
- ACK_TIMEOUT, 255, cycles to wait for tx_ack or rx_ack before aborting the request; 0 disables the timeout.
- TX_GUARD, 1, cycles after tx_ack during which tx_empty is ignored (covers the UART's one-cycle empty-update lag).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tto_load  in  1  one-cycle strobe: send tto_data.
- tto_data  in  8  byte to transmit.
- tto_flag_clr  in  1  clear TTO done flag.
- tto_flag  out  1  TTO done (ready for next byte).
- tti_flag_clr  in  1  clear TTI flag (byte consumed).
- tti_flag  out  1  TTI byte available.
- tti_data  out  8  captured receive byte.
- ack_err  out  1  sticky: a request timed out; cleared only by reset.
- irq  out  1  interrupt request.
- tx_req  out  1  transmit request to UART.
- tx_data  out  8  transmit byte to UART.
- tx_ack  in  1  UART accepted byte (one-cycle pulse).
- tx_empty  in  1  UART transmitter idle.
- rx_req  out  1  receive request to UART.
- rx_ack  in  1  UART acknowledges receive request (one-cycle pulse).
- rx_empty  in  1  UART has no pending byte.
- rx_data  in  8  UART receive byte; valid the cycle after rx_ack.

Behaviour:
- Reset (async, active-high): TX FSM=T_IDLE, RX FSM=R_IDLE; tx_req=0, rx_req=0, tx_data=0, tti_data=0, tto_flag=0, tti_flag=0, ack_err=0, irq=0, all counters=0. Reset mid-handshake drops the request immediately; the partial byte is lost.
- TX FSM:
  - T_IDLE: on tto_load, latch tto_data into tx_data, clear tto_flag, go to T_REQ.
  - T_REQ: tx_req=1. On tx_ack go to T_GUARD. If the timeout counter reaches ACK_TIMEOUT, set ack_err and tto_flag, go to T_IDLE.
  - T_GUARD: tx_req=0; hold for TX_GUARD cycles, then go to T_BUSY.
  - T_BUSY: when tx_empty=1, set tto_flag and go to T_IDLE.
- tto_load outside T_IDLE is ignored; tx_data stays stable until the next accepted load.
- Simultaneous tto_load and tto_flag_clr in T_IDLE: the load is taken and the flag ends 0.
- Minimum accepted-load to tto_flag latency = 1 (T_REQ) + ack wait + TX_GUARD + drain.
- RX FSM:
  - R_IDLE: if rx_empty=0 and tti_flag=0, go to R_REQ.
  - R_REQ: rx_req=1. On rx_ack go to R_CAP. On timeout, set ack_err and go to R_IDLE.
  - R_CAP: rx_req=0; at the edge leaving R_CAP, latch rx_data into tti_data, set tti_flag, go to R_IDLE.
- tti_flag=1 blocks further rx requests, so no overrun is possible; the UART holds the data.
- tti_flag_clr in the same cycle as the R_CAP set: set wins.
- tti_data holds until the next capture.
- Timeout counter: 8 bits, saturating; zeroed on entry to T_REQ or R_REQ. TX and RX use independent counters.
- irq = tto_flag | tti_flag (no enable; see Optional Feature).

Optional Feature:
- Macro KL8E_IRQ_EN.
- Defined:
  - Adds input ie_set (1) and input ie_clr (1) plus an internal ie register (reset 1).
  - ie_clr has priority over ie_set when both are asserted.
  - irq = ie & (tto_flag | tti_flag).
- Undefined: ports absent; irq = tto_flag | tti_flag.

Decomposition:
- Package kl8e_pkg holds:
  - TX state encodings T_IDLE=0, T_REQ=1, T_GUARD=2, T_BUSY=3.
  - RX state encodings R_IDLE=0, R_REQ=1, R_CAP=2.
  - Constant TIMEOUT_W=8.
- One natural sub-module: kl8e_req_timer, the saturating timeout counter, instantiated once for TX and once for RX.
- The FSMs stay in the top module.

Test Plan:
- Bench UART model: tx_ack the cycle after tx_req, tx_empty low for 20 cycles after ack. Stimulus: tto_load with 8'h53 → tx_req high exactly until tx_ack, tx_data=8'h53, tto_flag=1 about 21 cycles after ack, tto_flag=0 during the transfer.
- Model holds the bytes "START\r" and tti_flag_clr is pulsed after each flag → tti_data = 8'h53, 8'h54, 8'h41, 8'h52, 8'h54, 8'h0D in order; never two rx_req while tti_flag=1; idle once rx_empty=1.
- Second tto_load with 8'h41 while in T_BUSY → ignored; tx_data stays 8'h53, and exactly one tx_req pulse occurs.
- Model never acks, ACK_TIMEOUT=4 → tx_req drops 4 cycles after assertion, ack_err=1, tto_flag=1.
- Assert reset in T_REQ and in R_CAP → tx_req=rx_req=0 in the same cycle (async), all flags 0, tti_data=0; normal operation resumes after release.
- With KL8E_IRQ_EN defined: ie_clr, then a byte is received → tti_flag=1, irq=0; ie_set → irq=1 the next cycle.
